// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory, and buffers returned words with their PCs for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic            r_run;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic            w_credit_ok;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redirect_pc;

    // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
    assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign imem_req_valid = r_run && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push         = imem_rsp_valid && !redirect_valid && (r_discard == '0);
    assign instr_valid    = (r_count != '0) && !redirect_valid;
    assign w_pop          = instr_valid && instr_ready;
    assign instr          = r_mem[r_rd_ptr].word;
    assign instr_pc       = r_mem[r_rd_ptr].pc;
    assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;

    // Prefetch storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= entry_t'{pc: r_rsp_pc, word: imem_rsp_data};
        end
    end

    // PCs, FIFO pointers and credit/discard bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Every response still owed to the old stream must be dropped.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_discard  <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a queue-based memory and
// prefetch reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    req_t        pend[$];
    ent_t        mfifo[$];
    int          m_discard;
    logic [31:0] m_req_addr, m_rsp_pc, m_stream_pc;
    bit          m_run;
    int          cyc, mem_lat;
    int          total, bad;

    bit          drv_req_ready, drv_instr_ready, drv_redirect;
    logic [31:0] drv_redirect_pc;

    bit          o_req_valid, o_req_fire, o_instr_valid, o_pop;
    logic [31:0] o_req_addr, o_instr_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        pend.delete();
        mfifo.delete();
        m_discard   = 0;
        m_req_addr  = RPC;
        m_rsp_pc    = RPC;
        m_stream_pc = RPC;
        m_run       = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check against model, advance model.
    task automatic step();
        bit          rsp, exp_rv, exp_iv;
        logic [31:0] rdata;
        rsp   = (pend.size() > 0) && (pend[0].due <= cyc);
        rdata = rsp ? mem_word(pend[0].addr) : 32'($urandom);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        imem_req_ready = drv_req_ready;
        instr_ready    = drv_instr_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        #1;
        exp_rv = m_run && !drv_redirect && ((mfifo.size() + pend.size()) < DEPTH);
        exp_iv = !drv_redirect && (mfifo.size() != 0);
        total++;
        if (imem_req_valid !== exp_rv) begin
            bad++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            total++;
            if (imem_req_addr !== m_req_addr) begin
                bad++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_req_addr);
            end
        end
        total++;
        if (instr_valid !== exp_iv) begin
            bad++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_iv);
        end
        if (exp_iv) begin
            total++;
            if (instr_pc !== mfifo[0].pc || instr !== mfifo[0].word) begin
                bad++;
                $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, instr_pc, instr,
                         mfifo[0].pc, mfifo[0].word);
            end
        end
        o_req_valid   = imem_req_valid;
        o_req_addr    = imem_req_addr;
        o_req_fire    = imem_req_valid && imem_req_ready;
        o_instr_valid = instr_valid;
        o_instr_pc    = instr_pc;
        o_pop         = instr_valid && instr_ready;
        if (o_pop) begin
            total++;
            if (instr_pc !== m_stream_pc || instr !== mem_word(m_stream_pc)) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%h/%h exp=%h/%h", cyc, instr_pc, instr,
                         m_stream_pc, mem_word(m_stream_pc));
            end
            m_stream_pc += 32'd4;
        end
        if (rsp) pend.delete(0);
        if (drv_redirect) begin
            mfifo.delete();
            m_discard   = pend.size();
            m_req_addr  = drv_redirect_pc & 32'hFFFF_FFFC;
            m_rsp_pc    = m_req_addr;
            m_stream_pc = m_req_addr;
        end else begin
            if (o_pop && mfifo.size() > 0) mfifo.delete(0);
            if (rsp) begin
                if (m_discard > 0) m_discard--;
                else begin
                    mfifo.push_back('{pc: m_rsp_pc, word: rdata});
                    m_rsp_pc += 32'd4;
                end
            end
            if (o_req_fire) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                m_req_addr += 32'd4;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_drive(input bit rq, input bit ir);
        drv_req_ready   = rq;
        drv_instr_ready = ir;
        drv_redirect    = 1'b0;
    endtask

    // Release reset at a negedge and check first-request and first-instr timing.
    task automatic release_and_check(input string tag);
        int npop;
        rst_n = 1'b1;
        cyc   = 0;
        mem_lat = 1;
        set_drive(1'b1, 1'b1);
        step();
        total++;
        if (o_req_valid !== 1'b0) begin
            bad++; $display("FAIL %s_cyc0_req got=%b exp=0", tag, o_req_valid);
        end
        step();
        total++;
        if (o_req_valid !== 1'b1 || o_req_addr !== RPC) begin
            bad++; $display("FAIL %s_first_req got=%b/%h exp=1/%h", tag, o_req_valid, o_req_addr, RPC);
        end
        step();
        total++;
        if (o_instr_valid !== 1'b0) begin
            bad++; $display("FAIL %s_cyc2_iv got=%b exp=0", tag, o_instr_valid);
        end
        step();
        total++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== RPC) begin
            bad++; $display("FAIL %s_first_instr got=%b/%h exp=1/%h", tag, o_instr_valid, o_instr_pc, RPC);
        end
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_pop) npop++;
        end
        total++;
        if (npop != 8) begin
            bad++; $display("FAIL %s_throughput got=%0d exp=8", tag, npop);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%b/%h/%h exp=0/%h/0/0/0", imem_req_valid,
                     imem_req_addr, instr_valid, instr, instr_pc, RPC);
        end
        release_and_check("release");
    endtask

    task automatic test_backpressure();
        set_drive(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        total++;
        if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full got=req%b/iv%b exp=req0/iv1", o_req_valid, o_instr_valid);
        end
        set_drive(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_redirect_slow();
        bit seen;
        mem_lat = 3;
        set_drive(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_2003;
        step();
        drv_redirect = 1'b0;
        step();
        total++;
        if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_2000) begin
            bad++; $display("FAIL redir_next_req got=%b/%h exp=1/00002000", o_req_valid, o_req_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (o_pop) begin
                seen = 1'b1;
                total++;
                if (o_instr_pc !== 32'h0000_2000) begin
                    bad++; $display("FAIL redir_first_pc got=%h exp=00002000", o_instr_pc);
                end
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL redir_first_pc got=timeout exp=00002000");
        end
    endtask

    task automatic test_redirect_coincident();
        bit          seen;
        logic [31:0] tgt;
        mem_lat = 1;
        set_drive(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step();
        tgt = 32'($urandom) & 32'h00FF_FFFC;
        total++;
        if (!(pend.size() > 0 && pend[0].due <= cyc)) begin
            bad++; $display("FAIL coinc_setup got=no_rsp exp=rsp_pending");
        end
        drv_redirect = 1'b1; drv_redirect_pc = tgt | 32'h1;
        step();
        drv_redirect = 1'b0;
        total++;
        if (o_instr_valid !== 1'b0 || o_pop !== 1'b0 || o_req_valid !== 1'b0) begin
            bad++; $display("FAIL coinc_cycle got=iv%b/pop%b/rv%b exp=0/0/0", o_instr_valid, o_pop, o_req_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (o_pop) begin
                seen = 1'b1;
                total++;
                if (o_instr_pc !== tgt) begin
                    bad++; $display("FAIL coinc_first_pc got=%h exp=%h", o_instr_pc, tgt);
                end
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL coinc_first_pc got=timeout exp=%h", tgt);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_random();
        int nacc;
        nacc = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) mem_lat = $urandom_range(1, 3);
            drv_req_ready   = ($urandom % 2) == 0;
            drv_instr_ready = $urandom_range(0, 3) != 0;
            drv_redirect    = (i > 100) && ($urandom_range(0, 29) == 0);
            drv_redirect_pc = 32'($urandom);
            step();
            if (o_req_fire) nacc++;
        end
        set_drive(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step();
        total++;
        if (nacc < 100) begin
            bad++; $display("FAIL rand_progress got=%0d exp=>=100", nacc);
        end
    endtask

    task automatic test_reset_midstream();
        bit full;
        mem_lat = 1;
        set_drive(1'b1, 1'b0);
        full = 1'b0;
        for (int i = 0; i < 20 && !full; i++) begin
            step();
            full = (mfifo.size() == DEPTH);
        end
        total++;
        if (!full || o_instr_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_fill got=full%b/iv%b exp=1/1", full, o_instr_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b/%h/%b/%h/%h exp=0/%h/0/0/0", imem_req_valid,
                     imem_req_addr, instr_valid, instr, instr_pc, RPC);
        end
        imem_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        release_and_check("midrst");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        mem_lat = 1;
        drv_redirect_pc = '0;
        set_drive(1'b0, 1'b0);
        test_reset();
        test_backpressure();
        test_redirect_slow();
        test_redirect_coincident();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
